cic_interp_sequencer: RTL
=========================

Name: cic_interp_sequencer

Overview:
- Sequences the CIC interpolator datapath ahead of the delta-sigma modulator.
- Accepts input-rate samples over a valid/ready handshake and holds them in a one-entry buffer.
- Generates the low-rate comb strobe with its sample, the high-rate integrator clock enable, and the datapath reset.
- Manages start-up (prime), steady run, underrun and drain (flush) so the integrator chain starts clean and ends at zero.

Parameters:
- WIDTH, 16, input sample width (signed two's complement).
- R, 16, interpolation ratio; comb strobe period in clk cycles; R >= 2.
- FLUSH_LEN, 64, clk cycles of zero-input drain after enable drops; >= 1.
- PHASE_W, $clog2(R), phase counter width (derived).
- FLUSH_W, $clog2(FLUSH_LEN+1), flush counter width (derived).

Ports:
- clk  in  1  system clock (modulator rate).
- rst  in  1  asynchronous active-low reset.
- enable  in  1  level; high requests streaming, low requests drain and stop.
- clr_underrun  in  1  single-cycle pulse; clears the underrun flag.
- s_data  in  WIDTH  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer can accept a sample.
- comb_en  out  1  one-cycle strobe; comb stage consumes comb_data.
- comb_data  out  WIDTH  sample presented to the comb stage.
- integ_en  out  1  clock enable for the integrator chain.
- dp_rst_n  out  1  active-low datapath reset for the comb/integrator registers.
- underrun  out  1  sticky; a phase boundary found the buffer empty.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst low) values:
  - state = IDLE, phase = 0, flush_cnt = 0.
  - Buffer empty; comb_data = 0.
  - s_ready = 0, comb_en = 0, integ_en = 0, dp_rst_n = 0, underrun = 0, busy = 0.
- State IDLE:
  - dp_rst_n = 0, s_ready = 0, integ_en = 0.
  - enable = 1 -> PRIME next cycle, and underrun clears.
- State PRIME:
  - dp_rst_n = 1, integ_en = 0, s_ready = !hold_valid.
  - The first accepted sample sets hold_valid. When hold_valid = 1 -> RUN with phase = R-1.
  - enable = 0 in PRIME -> IDLE; any held sample is discarded.
- State RUN:
  - integ_en = 1 every cycle. phase counts R-1, 0, 1, …, R-1 (wraps to 0 after R-1).
  - At phase == R-1:
    - comb_data <= hold_data if hold_valid, and hold_valid clears.
    - Otherwise comb_data <= 0 and underrun <= 1.
  - comb_en = 1 exactly when phase == 0, i.e. one strobe every R cycles.
  - s_ready = !hold_valid. A handshake (s_valid & s_ready) loads the buffer.
  - Full buffer at phase R-1: consume on that edge; s_ready rises the next cycle. A sample is never lost or duplicated.
  - First comb_en comes 1 cycle after entering RUN and carries the primed sample.
  - enable = 0 sampled in RUN -> FLUSH next cycle; flush_cnt = FLUSH_LEN; the held sample is discarded.
- State FLUSH:
  - s_ready = 0, integ_en = 1, dp_rst_n = 1. The phase counter keeps running.
  - comb_data is forced to 0 at each phase R-1 load; comb_en keeps its R-cycle cadence. Underrun is not set.
  - flush_cnt decrements each cycle. At 1 -> IDLE.
  - enable re-asserting during FLUSH is ignored; the flush completes and IDLE then restarts via PRIME.
- underrun:
  - Sets only in RUN.
  - clr_underrun clears it. Simultaneous set and clear -> set wins.
- Outputs:
  - comb_en, integ_en, s_ready, dp_rst_n and busy are decoded from registered state/phase/hold_valid only; no combinational path from s_valid or enable.
  - comb_data and underrun are registers.
- Async reset mid-operation: all state is dropped immediately; dp_rst_n asserts low in the same instant. No partial drain.

Decomposition:
- Package cic_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} seq_state_t;
  - default constants CIC_R, CIC_N and CIC_GROWTH, shared with the integrator/comb stages.
- One natural sub-module: cic_sample_hold. It is the one-entry valid/ready buffer with load, consume and discard, instantiated once.
- FSM, phase counter and flush counter stay in the top module.

Test Plan (all with R=4, FLUSH_LEN=8):
- Reset then enable=1, s_data=0x0123 held valid -> PRIME 1 cycle; RUN; comb_en at cycles RUN+1, +5, +9; comb_data=0x0123 at the first strobe; dp_rst_n=1 from PRIME on.
- Stream 0x0001, 0x0002, 0x0003, with s_valid always high -> comb_data sequence 1, 2, 3 on consecutive strobes; s_ready high 1 cycle per 4; underrun stays 0.
- After the first sample, drop s_valid for 8 cycles -> next two strobes carry comb_data=0; underrun=1; clr_underrun pulse -> 0; set-and-clear in the same cycle -> 1.
- enable=0 mid-RUN with a buffered sample -> FLUSH; s_ready=0; the sample is dropped; integ_en high 8 cycles with zero comb_data; then IDLE, dp_rst_n=0, busy=0.
- enable toggles 1->0 in PRIME -> IDLE without RUN; enable high during FLUSH -> flush still completes, then PRIME.
- rst low asynchronously at phase 2 of RUN -> all outputs reach reset values before the next clk edge; after release, a normal restart matches scenario 1.

Source files
------------

// File: rtl/cic_interp_sequencer_pkg.sv
// Shared CIC types and default constants for the sequencer and datapath stages.
package cic_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} seq_state_t;

  localparam int CIC_R      = 16;
  localparam int CIC_N      = 4;
  // Interpolator DC gain is R^(N-1); this is the word growth it implies.
  localparam int CIC_GROWTH = (CIC_N - 1) * $clog2(CIC_R);

endpackage

// File: rtl/cic_interp_sequencer_sample_hold.sv
// One-entry valid/ready sample buffer with load, consume and discard.
module cic_sample_hold #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             consume,
  input  logic             discard,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data
);

  // Discard/consume win over load; load only happens while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (discard || consume) hold_valid <= 1'b0;
      else if (load)          hold_valid <= 1'b1;
      if (load && !discard)   hold_data  <= load_data;
    end
  end

endmodule

// File: rtl/cic_interp_sequencer.sv
// CIC interpolator sequencer: input buffering, comb strobe, integrator
// enable and datapath reset, with prime / run / underrun / flush control.
module cic_interp_sequencer
  import cic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int R         = 16,
  parameter int FLUSH_LEN = 64,
  parameter int PHASE_W   = $clog2(R),
  parameter int FLUSH_W   = $clog2(FLUSH_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr_underrun,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             comb_en,
  output logic [WIDTH-1:0] comb_data,
  output logic             integ_en,
  output logic             dp_rst_n,
  output logic             underrun,
  output logic             busy
);

  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(R - 1);

  seq_state_t         state, state_d;
  logic [PHASE_W-1:0] phase, phase_d;
  logic [FLUSH_W-1:0] flush_cnt, flush_d;
  logic               hold_valid;
  logic [WIDTH-1:0]   hold_data;
  logic               hs, consume, discard, set_under, comb_ld, last;

  cic_sample_hold #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hs),
    .load_data  (s_data),
    .consume    (consume),
    .discard    (discard),
    .hold_valid (hold_valid),
    .hold_data  (hold_data)
  );

  // State, phase and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase     <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      flush_cnt <= flush_d;
    end
  end

  // Output decode from registered state only, then next-state and datapath controls.
  always_comb begin
    s_ready   = (state == PRIME || state == RUN) && !hold_valid;
    integ_en  = (state == RUN || state == FLUSH);
    dp_rst_n  = (state != IDLE);
    busy      = (state != IDLE);
    last      = (phase == PH_LAST);
    comb_en   = integ_en && (phase == '0);
    hs        = s_valid && s_ready;
    state_d   = state;
    phase_d   = phase;
    flush_d   = flush_cnt;
    consume   = 1'b0;
    discard   = 1'b0;
    set_under = 1'b0;
    comb_ld   = integ_en && last;
    case (state)
      IDLE: begin
        phase_d = '0;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
          discard = 1'b1;
        end else if (hold_valid || hs) begin
          // Start one cycle before the first strobe so it carries the primed sample.
          state_d = RUN;
          phase_d = PH_LAST;
        end
      end
      RUN: begin
        phase_d = last ? '0 : phase + PHASE_W'(1);
        if (last) begin
          if (hold_valid) consume   = 1'b1;
          else            set_under = 1'b1;
        end
        if (!enable) begin
          state_d = FLUSH;
          flush_d = FLUSH_W'(FLUSH_LEN);
          discard = 1'b1;
        end
      end
      FLUSH: begin
        phase_d = last ? '0 : phase + PHASE_W'(1);
        flush_d = flush_cnt - FLUSH_W'(1);
        if (flush_cnt == FLUSH_W'(1)) begin
          state_d = IDLE;
          phase_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Comb sample register: buffered sample in RUN, zero on underrun or during flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         comb_data <= '0;
    else if (comb_ld) comb_data <= (state == RUN && hold_valid) ? hold_data : '0;
  end

  // Sticky underrun; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         underrun <= 1'b0;
    else if (set_under)                               underrun <= 1'b1;
    else if (clr_underrun || (state == IDLE && enable)) underrun <= 1'b0;
  end

endmodule
